// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the two-ball pool game: turn-controller state
// encoding, score and coordinate widths, respawn coordinates (also used by the
// ball movers), and a saturating score increment helper.
// -----------------------------------------------------------------------------
package pool_pkg;

    localparam int SCORE_W     = 4;
    localparam int COORD_W     = 11;
    localparam int FRAME_CNT_W = 16;

    // Restart positions shared with the ball movers
    localparam int POOL_RED_RESPAWN_X   = 280;
    localparam int POOL_RED_RESPAWN_Y   = 185;
    localparam int POOL_WHITE_RESPAWN_X = 120;
    localparam int POOL_WHITE_RESPAWN_Y = 185;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic [SCORE_W-1:0]        score_t;

    typedef enum logic [2:0] {
        S_AIM       = 3'd0,
        S_ARMING    = 3'd1,
        S_ROLLING   = 3'd2,
        S_SETTLING  = 3'd3,
        S_EVAL      = 3'd4,
        S_GAME_OVER = 3'd5
    } turn_state_t;

    // Score +1, holding at the maximum representable value
    function automatic score_t score_inc_sat(input score_t s);
        score_t r;
        if (s == SCORE_MAX) begin
            r = s;
        end else begin
            r = s + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_counter.sv
// -----------------------------------------------------------------------------
// frame_counter
// Counts startOfFrame pulses (gated by the caller through `inc`). `clear`
// dominates `inc` and returns the count to zero. `hit` flags, combinationally,
// that the pulse being counted this cycle brings the count to `terminal`.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clear           : force count to zero on the next edge
//   inc             : count one frame on the next edge
//   terminal        : terminal count compared against
//   hit             : inc is high and count+1 equals terminal
// -----------------------------------------------------------------------------
module frame_counter
    import pool_pkg::*;
#(
    parameter int W = FRAME_CNT_W
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] terminal,
    output logic         hit
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_plus_s;

    // Frame count register, clear has priority over increment
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= count_plus_s;
        end else begin
            count_r <= count_r;
        end
    end

    // Terminal compare on the value the count is about to take
    always_comb begin
        count_plus_s = count_r + W'(1);
        hit          = inc && (count_plus_s == terminal);
    end

endmodule

// File: rtl/pool_turn_manager.sv
// -----------------------------------------------------------------------------
// pool_turn_manager
// Referee for the two-ball pool game. Arms a shot, watches the roll, waits
// for both balls to settle (or the roll to time out), scores the turn, picks
// the next shooter and emits one turn_over pulse with restart positions.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   startOfFrame                    : one-clock pulse per video frame
//   shot_fired                      : cue strike request (accepted in AIM only)
//   red/white_ball_stopped          : ball speed is zero
//   collision_Red_Black/White_Black : ball is in a pocket
//   red/white_x/y_loc               : current ball positions
//   shot_enable                     : high while waiting for a shot
//   turn_over                       : one-clock end-of-turn pulse
//   new_red/white_x/y_loc           : restart positions, valid with turn_over
//   player, score_p0, score_p1      : current shooter and scores
//   game_over                       : a player has reached WIN_SCORE
// -----------------------------------------------------------------------------
module pool_turn_manager
    import pool_pkg::*;
#(
    parameter int RED_RESPAWN_X   = POOL_RED_RESPAWN_X,
    parameter int RED_RESPAWN_Y   = POOL_RED_RESPAWN_Y,
    parameter int WHITE_RESPAWN_X = POOL_WHITE_RESPAWN_X,
    parameter int WHITE_RESPAWN_Y = POOL_WHITE_RESPAWN_Y,
    parameter int ARM_FRAMES      = 2,
    parameter int SETTLE_FRAMES   = 4,
    parameter int MAX_ROLL_FRAMES = 600,
    parameter int WIN_SCORE       = 5
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      shot_fired,
    input  logic                      red_ball_stopped,
    input  logic                      white_ball_stopped,
    input  logic                      collision_Red_Black,
    input  logic                      collision_White_Black,
    input  logic signed [COORD_W-1:0] red_x_loc,
    input  logic signed [COORD_W-1:0] red_y_loc,
    input  logic signed [COORD_W-1:0] white_x_loc,
    input  logic signed [COORD_W-1:0] white_y_loc,
    output logic                      shot_enable,
    output logic                      turn_over,
    output logic signed [COORD_W-1:0] new_red_x_loc,
    output logic signed [COORD_W-1:0] new_red_y_loc,
    output logic signed [COORD_W-1:0] new_white_x_loc,
    output logic signed [COORD_W-1:0] new_white_y_loc,
    output logic                      player,
    output logic [SCORE_W-1:0]        score_p0,
    output logic [SCORE_W-1:0]        score_p1,
    output logic                      game_over
);

    localparam coord_t RED_RX_C   = coord_t'(RED_RESPAWN_X);
    localparam coord_t RED_RY_C   = coord_t'(RED_RESPAWN_Y);
    localparam coord_t WHITE_RX_C = coord_t'(WHITE_RESPAWN_X);
    localparam coord_t WHITE_RY_C = coord_t'(WHITE_RESPAWN_Y);

    turn_state_t cur_state_r, next_state_s;

    logic   shot_enable_r, turn_over_r, game_over_r, player_r;
    logic   red_potted_r, white_potted_r;
    score_t score_p0_r, score_p1_r;
    coord_t new_red_x_r, new_red_y_r, new_white_x_r, new_white_y_r;

    logic   both_stopped_s, watching_s, shot_accept_s;
    logic   roll_inc_s, roll_clr_s, roll_hit_s;
    logic   settle_inc_s, settle_clr_s, settle_hit_s;
    logic [FRAME_CNT_W-1:0] roll_term_s;
    logic [FRAME_CNT_W-1:0] settle_term_s;

    logic   foul_s, pot_s, player_next_s, win_s;
    score_t score_p0_next_s, score_p1_next_s;
    coord_t red_x_next_s, red_y_next_s, white_x_next_s, white_y_next_s;

    // Shots are only taken while shot_enable is shown, which also keeps the
    // turn_over cycle (state already AIM) from accepting a shot.
    assign both_stopped_s = red_ball_stopped && white_ball_stopped;
    assign watching_s     = (cur_state_r == S_ROLLING) || (cur_state_r == S_SETTLING);
    assign shot_accept_s  = (cur_state_r == S_AIM) && shot_enable_r && shot_fired;

    // One counter covers arming then rolling; it restarts from zero when
    // ARMING hands over, so the roll timeout counts from leaving ARMING.
    assign roll_inc_s  = startOfFrame && ((cur_state_r == S_ARMING) || (cur_state_r == S_ROLLING));
    assign roll_clr_s  = shot_accept_s || ((cur_state_r == S_ARMING) && roll_hit_s);
    assign roll_term_s = (cur_state_r == S_ARMING) ? FRAME_CNT_W'(ARM_FRAMES)
                                                   : FRAME_CNT_W'(MAX_ROLL_FRAMES);

    // The first both-stopped frame seen in ROLLING counts as settle frame 1;
    // any moving frame zeroes the settle count.
    assign settle_inc_s  = startOfFrame && watching_s && both_stopped_s;
    assign settle_clr_s  = shot_accept_s || (startOfFrame && watching_s && !both_stopped_s);
    assign settle_term_s = FRAME_CNT_W'(SETTLE_FRAMES);

    frame_counter #(.W(FRAME_CNT_W)) u_roll_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (roll_clr_s),
        .inc      (roll_inc_s),
        .terminal (roll_term_s),
        .hit      (roll_hit_s)
    );

    frame_counter #(.W(FRAME_CNT_W)) u_settle_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (settle_clr_s),
        .inc      (settle_inc_s),
        .terminal (settle_term_s),
        .hit      (settle_hit_s)
    );

    // Turn scoring: a potted white is a foul and outranks a red pot
    always_comb begin
        foul_s          = white_potted_r;
        pot_s           = red_potted_r && !white_potted_r;
        score_p0_next_s = score_p0_r;
        score_p1_next_s = score_p1_r;
        player_next_s   = player_r;
        if (foul_s) begin
            if (player_r) begin
                score_p0_next_s = score_inc_sat(score_p0_r);
            end else begin
                score_p1_next_s = score_inc_sat(score_p1_r);
            end
            player_next_s = !player_r;
        end else if (pot_s) begin
            if (player_r) begin
                score_p1_next_s = score_inc_sat(score_p1_r);
            end else begin
                score_p0_next_s = score_inc_sat(score_p0_r);
            end
        end else begin
            player_next_s = !player_r;
        end
        red_x_next_s   = red_potted_r ? RED_RX_C : red_x_loc;
        red_y_next_s   = red_potted_r ? RED_RY_C : red_y_loc;
        white_x_next_s = foul_s ? WHITE_RX_C : white_x_loc;
        white_y_next_s = foul_s ? WHITE_RY_C : white_y_loc;
        win_s = (int'(score_p0_next_s) == WIN_SCORE) || (int'(score_p1_next_s) == WIN_SCORE);
    end

    // Next-state logic
    always_comb begin
        next_state_s = cur_state_r;
        case (cur_state_r)
            S_AIM: begin
                if (shot_accept_s) next_state_s = S_ARMING;
                else               next_state_s = S_AIM;
            end
            S_ARMING: begin
                if (roll_hit_s) next_state_s = S_ROLLING;
                else            next_state_s = S_ARMING;
            end
            S_ROLLING: begin
                if (roll_hit_s || settle_hit_s)          next_state_s = S_EVAL;
                else if (startOfFrame && both_stopped_s) next_state_s = S_SETTLING;
                else                                     next_state_s = S_ROLLING;
            end
            S_SETTLING: begin
                if (settle_hit_s)                         next_state_s = S_EVAL;
                else if (startOfFrame && !both_stopped_s) next_state_s = S_ROLLING;
                else                                      next_state_s = S_SETTLING;
            end
            S_EVAL: begin
                if (win_s) next_state_s = S_GAME_OVER;
                else       next_state_s = S_AIM;
            end
            S_GAME_OVER: next_state_s = S_GAME_OVER;
            default:     next_state_s = S_AIM;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state_r <= S_AIM;
        end else begin
            cur_state_r <= next_state_s;
        end
    end

    // Pot flags, scores, player, restart positions and registered flags
    always_ff @(posedge clk) begin
        if (reset) begin
            shot_enable_r  <= 1'b1;
            turn_over_r    <= 1'b0;
            game_over_r    <= 1'b0;
            player_r       <= 1'b0;
            red_potted_r   <= 1'b0;
            white_potted_r <= 1'b0;
            score_p0_r     <= 4'd0;
            score_p1_r     <= 4'd0;
            new_red_x_r    <= RED_RX_C;
            new_red_y_r    <= RED_RY_C;
            new_white_x_r  <= WHITE_RX_C;
            new_white_y_r  <= WHITE_RY_C;
        end else begin
            // The cycle after EVAL carries turn_over; enable waits one more
            shot_enable_r <= (next_state_s == S_AIM) && (cur_state_r != S_EVAL);
            turn_over_r   <= (cur_state_r == S_EVAL);
            game_over_r   <= (cur_state_r == S_GAME_OVER);
            if (shot_accept_s) begin
                red_potted_r   <= 1'b0;
                white_potted_r <= 1'b0;
            end else if (watching_s) begin
                red_potted_r   <= red_potted_r   || collision_Red_Black;
                white_potted_r <= white_potted_r || collision_White_Black;
            end else begin
                red_potted_r   <= red_potted_r;
                white_potted_r <= white_potted_r;
            end
            if (cur_state_r == S_EVAL) begin
                player_r      <= player_next_s;
                score_p0_r    <= score_p0_next_s;
                score_p1_r    <= score_p1_next_s;
                new_red_x_r   <= red_x_next_s;
                new_red_y_r   <= red_y_next_s;
                new_white_x_r <= white_x_next_s;
                new_white_y_r <= white_y_next_s;
            end else begin
                player_r      <= player_r;
                score_p0_r    <= score_p0_r;
                score_p1_r    <= score_p1_r;
                new_red_x_r   <= new_red_x_r;
                new_red_y_r   <= new_red_y_r;
                new_white_x_r <= new_white_x_r;
                new_white_y_r <= new_white_y_r;
            end
        end
    end

    assign shot_enable     = shot_enable_r;
    assign turn_over       = turn_over_r;
    assign game_over       = game_over_r;
    assign player          = player_r;
    assign score_p0        = score_p0_r;
    assign score_p1        = score_p1_r;
    assign new_red_x_loc   = new_red_x_r;
    assign new_red_y_loc   = new_red_y_r;
    assign new_white_x_loc = new_white_x_r;
    assign new_white_y_loc = new_white_y_r;

endmodule

// File: tb/tb_pool_turn_manager.sv
// -----------------------------------------------------------------------------
// tb_pool_turn_manager
// Self-checking bench for pool_turn_manager: reset values, a table of scripted
// turns with hand-computed results, settle-restart / timeout / win / reset
// sequences, and random turns checked against a game-rules model.
// -----------------------------------------------------------------------------
module tb_pool_turn_manager;

    localparam int ARM     = 2;
    localparam int SETTLE  = 4;
    localparam int MAXROLL = 600;
    localparam int RRX = 280, RRY = 185, WRX = 120, WRY = 185;

    logic clk = 1'b0;
    logic reset, startOfFrame, shot_fired;
    logic red_ball_stopped, white_ball_stopped;
    logic collision_Red_Black, collision_White_Black;
    logic signed [10:0] red_x_loc, red_y_loc, white_x_loc, white_y_loc;
    logic shot_enable, turn_over, player, game_over;
    logic signed [10:0] new_red_x_loc, new_red_y_loc, new_white_x_loc, new_white_y_loc;
    logic [3:0] score_p0, score_p1;

    int n_vec = 0;
    int n_bad = 0;
    int to_cnt = 0;
    logic to_prev = 1'b0;
    int cap_pl, cap_s0, cap_s1, cap_rx, cap_ry, cap_wx, cap_wy;

    // Game-rules model
    int m_score[2];
    int m_player;
    int m_rx, m_ry, m_wx, m_wy;
    bit m_over;

    typedef struct {
        bit rp; bit wp; bit late;
        int rx; int ry; int wx; int wy;
        int e_pl; int e_s0; int e_s1;
        int e_rx; int e_ry; int e_wx; int e_wy;
    } vec_t;
    vec_t tbl[9];

    pool_turn_manager dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .shot_fired(shot_fired),
        .red_ball_stopped(red_ball_stopped), .white_ball_stopped(white_ball_stopped),
        .collision_Red_Black(collision_Red_Black), .collision_White_Black(collision_White_Black),
        .red_x_loc(red_x_loc), .red_y_loc(red_y_loc),
        .white_x_loc(white_x_loc), .white_y_loc(white_y_loc),
        .shot_enable(shot_enable), .turn_over(turn_over),
        .new_red_x_loc(new_red_x_loc), .new_red_y_loc(new_red_y_loc),
        .new_white_x_loc(new_white_x_loc), .new_white_y_loc(new_white_y_loc),
        .player(player), .score_p0(score_p0), .score_p1(score_p1), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Turn-over monitor: counts pulses, captures results, checks pulse shape
    always @(negedge clk) begin
        if (!reset) begin
            if (turn_over) begin
                to_cnt++;
                cap_pl = int'(player);
                cap_s0 = int'(score_p0);
                cap_s1 = int'(score_p1);
                cap_rx = int'(new_red_x_loc);
                cap_ry = int'(new_red_y_loc);
                cap_wx = int'(new_white_x_loc);
                cap_wy = int'(new_white_y_loc);
                chk("turn_over_width", int'(to_prev), 0);
                chk("enable_during_turn_over", int'(shot_enable), 0);
            end else if (to_prev) begin
                chk("enable_after_turn_over", int'(shot_enable | game_over), 1);
            end
        end
        to_prev = turn_over;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_pos(input int rx, input int ry, input int wx, input int wy);
        red_x_loc   = 11'(rx);
        red_y_loc   = 11'(ry);
        white_x_loc = 11'(wx);
        white_y_loc = 11'(wy);
    endtask

    task automatic pulse_coll(input bit rp, input bit wp);
        collision_Red_Black   = rp;
        collision_White_Black = wp;
        tick();
        collision_Red_Black   = 1'b0;
        collision_White_Black = 1'b0;
    endtask

    task automatic shoot_and_arm();
        int w;
        w = 0;
        while (!shot_enable && w < 20) begin
            tick();
            w++;
        end
        chk("shot_enable_ready", int'(shot_enable), 1);
        red_ball_stopped   = 1'b0;
        white_ball_stopped = 1'b0;
        shot_fired = 1'b1;
        tick();
        shot_fired = 1'b0;
        chk("shot_enable_drop", int'(shot_enable), 0);
        repeat (ARM) frame();
    endtask

    task automatic wait_turn(input int to0, input int expected);
        for (int i = 0; i < 12 && to_cnt == to0; i++) tick();
        tick();
        tick();
        chk("turn_over_pulses", to_cnt - to0, expected);
    endtask

    // One full turn: shoot, roll, optional pots (rolling or settling), settle
    task automatic do_turn(input bit rp, input bit wp, input bit late,
                           input int rx, input int ry, input int wx, input int wy);
        int to0;
        to0 = to_cnt;
        shoot_and_arm();
        frame();
        if (!late) pulse_coll(rp, wp);
        frame();
        set_pos(rx, ry, wx, wy);
        red_ball_stopped   = 1'b1;
        white_ball_stopped = 1'b1;
        frame();
        if (late) pulse_coll(rp, wp);
        repeat (SETTLE - 1) frame();
        wait_turn(to0, 1);
    endtask

    task automatic check_result(input int pl, input int s0, input int s1,
                                input int rx, input int ry, input int wx, input int wy);
        chk("player", cap_pl, pl);
        chk("score_p0", cap_s0, s0);
        chk("score_p1", cap_s1, s1);
        chk("new_red_x", cap_rx, rx);
        chk("new_red_y", cap_ry, ry);
        chk("new_white_x", cap_wx, wx);
        chk("new_white_y", cap_wy, wy);
        chk("new_red_x_hold", int'(new_red_x_loc), rx);
    endtask

    task automatic model_reset();
        m_score[0] = 0;
        m_score[1] = 0;
        m_player = 0;
        m_over = 1'b0;
    endtask

    task automatic model_turn(input bit rp, input bit wp,
                              input int rx, input int ry, input int wx, input int wy);
        if (wp) begin
            if (m_score[1 - m_player] < 15) m_score[1 - m_player]++;
            m_player = 1 - m_player;
            m_wx = WRX; m_wy = WRY;
            m_rx = rp ? RRX : rx;
            m_ry = rp ? RRY : ry;
        end else if (rp) begin
            if (m_score[m_player] < 15) m_score[m_player]++;
            m_rx = RRX; m_ry = RRY;
            m_wx = wx;  m_wy = wy;
        end else begin
            m_player = 1 - m_player;
            m_rx = rx; m_ry = ry;
            m_wx = wx; m_wy = wy;
        end
        m_over = (m_score[0] == 5) || (m_score[1] == 5);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int to0;
        bit rp, wp, late;
        int rx, ry, wx, wy;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 400, 300, 100, 150, 0, 1, 0, 280, 185, 100, 150};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 300, 200,  50,  60, 1, 1, 0, 300, 200,  50,  60};
        tbl[2] = '{1'b0, 1'b0, 1'b0,  10,  20,  30,  40, 0, 1, 0,  10,  20,  30,  40};
        tbl[3] = '{1'b1, 1'b1, 1'b0,   5,   5,   6,   6, 1, 1, 1, 280, 185, 120, 185};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 222, 111,   7,   8, 0, 2, 1, 222, 111, 120, 185};
        tbl[5] = '{1'b1, 1'b0, 1'b0,  15,  16,  77,  88, 0, 3, 1, 280, 185,  77,  88};
        tbl[6] = '{1'b1, 1'b0, 1'b1,   1,   2,   9,   9, 0, 4, 1, 280, 185,   9,   9};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 333, 222,  44,  55, 1, 4, 1, 333, 222,  44,  55};
        tbl[8] = '{1'b1, 1'b0, 1'b1,  60,  70,  12,  13, 1, 4, 2, 280, 185,  12,  13};

        startOfFrame = 1'b0; shot_fired = 1'b0;
        red_ball_stopped = 1'b1; white_ball_stopped = 1'b1;
        collision_Red_Black = 1'b0; collision_White_Black = 1'b0;
        set_pos(0, 0, 0, 0);

        // Reset values
        do_reset();
        chk("rst_shot_enable", int'(shot_enable), 1);
        chk("rst_turn_over", int'(turn_over), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_player", int'(player), 0);
        chk("rst_score_p0", int'(score_p0), 0);
        chk("rst_score_p1", int'(score_p1), 0);
        chk("rst_new_red_x", int'(new_red_x_loc), RRX);
        chk("rst_new_red_y", int'(new_red_y_loc), RRY);
        chk("rst_new_white_x", int'(new_white_x_loc), WRX);
        chk("rst_new_white_y", int'(new_white_y_loc), WRY);

        // Scripted turns
        for (int i = 0; i < 9; i++) begin
            do_turn(tbl[i].rp, tbl[i].wp, tbl[i].late, tbl[i].rx, tbl[i].ry, tbl[i].wx, tbl[i].wy);
            check_result(tbl[i].e_pl, tbl[i].e_s0, tbl[i].e_s1,
                         tbl[i].e_rx, tbl[i].e_ry, tbl[i].e_wx, tbl[i].e_wy);
        end

        // Settle restart: two stopped frames, one moving, then 4 fresh ones
        do_reset();
        to0 = to_cnt;
        shoot_and_arm();
        set_pos(111, 222, 333, 44);
        red_ball_stopped = 1'b1; white_ball_stopped = 1'b1;
        frame(); frame();
        red_ball_stopped = 1'b0;
        frame();
        red_ball_stopped = 1'b1;
        repeat (SETTLE - 1) frame();
        tick(); tick(); tick();
        chk("settle_restart_early", to_cnt - to0, 0);
        frame();
        wait_turn(to0, 1);
        check_result(1, 0, 0, 111, 222, 333, 44);

        // Roll timeout: balls never stop
        do_reset();
        to0 = to_cnt;
        shoot_and_arm();
        set_pos(250, 150, 90, 95);
        repeat (MAXROLL - 1) frame();
        tick(); tick();
        chk("timeout_early", to_cnt - to0, 0);
        frame();
        wait_turn(to0, 1);
        check_result(1, 0, 0, 250, 150, 90, 95);

        // Win: player 0 pots five times, then shots are ignored
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_turn(1'b1, 1'b0, 1'b0, 30, 40, 50, 60);
            check_result(0, i + 1, 0, RRX, RRY, 50, 60);
            chk("game_over_flag", int'(game_over), (i == 4) ? 1 : 0);
        end
        chk("go_shot_enable", int'(shot_enable), 0);
        to0 = to_cnt;
        shot_fired = 1'b1;
        tick();
        shot_fired = 1'b0;
        red_ball_stopped = 1'b1; white_ball_stopped = 1'b1;
        repeat (8) frame();
        chk("go_no_turn", to_cnt - to0, 0);
        chk("go_shot_enable_held", int'(shot_enable), 0);
        chk("go_score_held", int'(score_p0), 5);
        chk("go_game_over_held", int'(game_over), 1);

        // Reset during ROLLING
        do_reset();
        do_turn(1'b1, 1'b0, 1'b0, 30, 40, 50, 60);
        shoot_and_arm();
        frame();
        to0 = to_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_shot_enable", int'(shot_enable), 1);
        chk("midrst_score_p0", int'(score_p0), 0);
        chk("midrst_player", int'(player), 0);
        red_ball_stopped = 1'b1; white_ball_stopped = 1'b1;
        repeat (6) frame();
        chk("midrst_no_turn", to_cnt - to0, 0);
        do_turn(1'b0, 1'b0, 1'b0, 300, 200, 10, 10);
        check_result(1, 0, 0, 300, 200, 10, 10);

        // Random turns against the rules model
        do_reset();
        model_reset();
        for (int t = 0; t < 40; t++) begin
            rp   = ($urandom_range(0, 2) == 0);
            wp   = ($urandom_range(0, 3) == 0);
            late = $urandom_range(0, 1) == 1;
            rx = $urandom_range(0, 620); ry = $urandom_range(0, 400);
            wx = $urandom_range(0, 620); wy = $urandom_range(0, 400);
            do_turn(rp, wp, late, rx, ry, wx, wy);
            model_turn(rp, wp, rx, ry, wx, wy);
            check_result(m_player, m_score[0], m_score[1], m_rx, m_ry, m_wx, m_wy);
            chk("rand_game_over", int'(game_over), m_over ? 1 : 0);
            if (m_over) begin
                do_reset();
                model_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pool_turn_manager.md
# pool_turn_manager

Turn/referee controller for the two-ball pool game. It is the consumer of the ball movers' `*_ball_stopped` and pocket-collision outputs, and the producer of their `turn_over` / `new_*_loc` inputs. It arms a shot, watches the roll, and waits for both balls to settle. It then scores the turn, selects the next player and issues a single `turn_over` pulse carrying the restart positions for both balls.

## Interface

**Clocking and reset:** one clock; reset is synchronous and active-high.

Parameters:
- `RED_RESPAWN_X`, default 280: red restart X after a pot.
- `RED_RESPAWN_Y`, default 185: red restart Y after a pot.
- `WHITE_RESPAWN_X`, default 120: white restart X after a foul.
- `WHITE_RESPAWN_Y`, default 185: white restart Y after a foul.
- `ARM_FRAMES`, default 2: frames ignored after a shot before stop-checking.
- `SETTLE_FRAMES`, default 4: consecutive both-stopped frames required.
- `MAX_ROLL_FRAMES`, default 600: roll timeout, in frames.
- `WIN_SCORE`, default 5: score that ends the game.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `startOfFrame`, in, 1: 1-clk pulse per frame.
- `shot_fired`, in, 1: cue strike request, 1-clk pulse.
- `red_ball_stopped`, in, 1: red speed is zero.
- `white_ball_stopped`, in, 1: white speed is zero.
- `collision_Red_Black`, in, 1: red is in a pocket.
- `collision_White_Black`, in, 1: white is in a pocket.
- `red_x_loc`, `red_y_loc`, in, 11 signed each: current red top-left.
- `white_x_loc`, `white_y_loc`, in, 11 signed each: current white top-left.
- `shot_enable`, out, 1: high only in AIM.
- `turn_over`, out, 1: 1-clk pulse at the end of a turn.
- `new_red_x_loc`, `new_red_y_loc`, out, 11 signed each: red restart position, valid with `turn_over`.
- `new_white_x_loc`, `new_white_y_loc`, out, 11 signed each: white restart position, valid with `turn_over`.
- `player`, out, 1: current shooter (0/1).
- `score_p0`, `score_p1`, out, 4 each: per-player scores.
- `game_over`, out, 1: a player has reached `WIN_SCORE`.

## Operation

**States:** AIM → ARMING → ROLLING → SETTLING → EVAL → AIM, plus a terminal GAME_OVER state.

- **AIM:** `shot_enable`=1. `shot_fired` → ARMING; clear the pot flags and the frame counters. `shot_fired` is ignored in every other state.
- **ARMING:** count `startOfFrame` pulses; after `ARM_FRAMES` pulses → ROLLING.
- **ROLLING:**
  - Pot flags: `red_potted` is set on any cycle `collision_Red_Black`=1, and `white_potted` on any cycle `collision_White_Black`=1. Both are sticky until the next shot.
  - Leaving: a frame with both stopped → SETTLING with settle count=1.
  - Timeout: when the roll frame count reaches `MAX_ROLL_FRAMES`, go directly → EVAL.
- **SETTLING:** on each `startOfFrame`, if both are stopped, increment the settle count; if either is moving, → ROLLING with settle count=0. At `SETTLE_FRAMES` → EVAL. Pot flags are still recorded in this state.
- **EVAL:** a single cycle that performs the scoring below and asserts `turn_over`.
  - Foul (`white_potted`=1):
    - opponent score +1;
    - `player` toggles;
    - white restarts at the WHITE_RESPAWN position;
    - red restarts at RED_RESPAWN if `red_potted`, otherwise at its current position;
    - the foul takes precedence over the pot, so the red pot earns no point.
  - Pot only (`red_potted`=1, `white_potted`=0): current player +1; `player` unchanged; red restarts at RED_RESPAWN; white stays at its current position.
  - Neither: `player` toggles; both balls stay at their current positions.
  - Next state: → GAME_OVER if either score now equals `WIN_SCORE`, otherwise → AIM.
- **GAME_OVER:** `game_over`=1, `shot_enable`=0; all inputs are ignored until `reset`.
- **Arithmetic:** scores saturate at 15. `new_*_loc` registers hold their value between pulses.

## Timing

**Reset values:**
- state = AIM, `player`=0, scores=0;
- `shot_enable`=1, `turn_over`=0, `game_over`=0;
- `new_red_*` = RED_RESPAWN, `new_white_*` = WHITE_RESPAWN.

**Cycle-level behaviour:**
- `shot_fired` sampled at cycle N: `shot_enable` is 0 at N+1.
- EVAL entered at cycle N:
  - `turn_over`=1 during cycle N+1 only;
  - `new_*_loc`, scores and `player` are updated in that same cycle;
  - `shot_enable`=1 (or `game_over`=1) from cycle N+2.
- Ball locations are sampled in the EVAL cycle.
- A `startOfFrame` coinciding with a state transition is consumed by the new state's counter only if the transition happened on an earlier cycle.
- **Reset mid-operation:** returns to AIM within one cycle. Scores are cleared and no `turn_over` is emitted.

## Structure

- **Shared package `pool_pkg`:**
  - `turn_state_t` enum;
  - score width constant (4);
  - coordinate width constant (11);
  - respawn coordinate constants, shared with the ball movers.
- **Sub-module `frame_counter`:**
  - counts `startOfFrame` pulses, with clear and terminal-count compare;
  - two instances: one for the arm/roll count, one for the settle count.
- **Top level:** the FSM and the scoring/position registers.

## Test plan

1. **Reset:** assert `reset` for 2 clocks → `shot_enable`=1, scores 0/0, `player`=0, `turn_over`=0, `new_red_x_loc`=280.
2. **Pot only:** `shot_fired`, pulse `collision_Red_Black` in ROLLING, then hold both stopped for 4 frames → one `turn_over` pulse, `score_p0`=1, `player`=0, `new_red_x_loc`/`new_red_y_loc` = 280/185, white location = current.
3. **Miss:** shot with no pots and balls stopping at red (300,200) → `turn_over` with `new_red` = (300,200); `player` becomes 1; scores unchanged.
4. **Foul:** red and white both potted in the same turn → `score_p1`=1, `player`=1, `new_white` = (120,185), `new_red` = (280,185).
5. **Settle restart and timeout:**
   - red restarts moving after 2 stopped frames → no EVAL until 4 fresh stopped frames;
   - balls never stop → `turn_over` 600 frames after leaving ARMING.
6. **Win and reset:**
   - player 0 pots 5 times → `game_over`=1 and `shot_fired` is ignored;
   - `reset` during ROLLING → AIM, scores 0, no `turn_over`.
